// File: rtl/scene_loader.sv
// Byte-stream scene loader: parses sync/command packets into object writes and a frame-aligned object count.
// Define SCENE_LOADER_CSUM_EN to require a trailing XOR checksum on write packets.
module scene_loader #(
  parameter int OBJ_WIDTH      = 384,
  parameter int OBJ_IDX_WIDTH  = 8,
  parameter int INIT_NUM_OBJS  = 1,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     frame_sync,
  output logic                     flash_obj_wen,
  output logic [OBJ_IDX_WIDTH-1:0] flash_obj_idx,
  output logic [OBJ_WIDTH-1:0]     flash_obj_data,
  output logic [OBJ_IDX_WIDTH-1:0] num_objs,
  output logic                     busy,
  output logic                     pkt_done,
  output logic [7:0]               err_cnt
);

  localparam int OBJ_BYTES = (OBJ_WIDTH + 7) / 8;
  localparam int BCW = $clog2(OBJ_BYTES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [8:0] IDX_LIM = 9'(1 << OBJ_IDX_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_IDX,
    S_DATA,
    S_COUNT,
`ifdef SCENE_LOADER_CSUM_EN
    S_CSUM,
`endif
    S_COMMIT
  } state_t;

  state_t                   state_q, state_d;
  logic [OBJ_IDX_WIDTH-1:0] idx_q, idx_d;
  logic [BCW-1:0]           bcnt_q, bcnt_d;
  logic [OBJ_WIDTH-1:0]     asm_q, asm_d;
  logic [TW-1:0]            tmo_q, tmo_d;
  logic [OBJ_IDX_WIDTH-1:0] pend_q, pend_d;
  logic [OBJ_IDX_WIDTH-1:0] num_q, num_d;
  logic [7:0]               err_q, err_d;
  logic                     cdone_q, cdone_d;
  logic [OBJ_IDX_WIDTH-1:0] oidx_q, oidx_d;
  logic [OBJ_WIDTH-1:0]     odata_q, odata_d;
`ifdef SCENE_LOADER_CSUM_EN
  logic [7:0]               csum_q, csum_d;
`endif
  logic                     acc;
  logic                     err;
  logic                     idx_ok;
  logic                     cnt_ok;

  assign in_ready       = (state_q != S_COMMIT);
  assign busy           = (state_q != S_IDLE);
  assign flash_obj_wen  = (state_q == S_COMMIT);
  assign pkt_done       = flash_obj_wen | cdone_q;
  assign flash_obj_idx  = oidx_q;
  assign flash_obj_data = odata_q;
  assign num_objs       = num_q;
  assign err_cnt        = err_q;

  assign acc    = in_valid & in_ready;
  assign idx_ok = ({1'b0, in_data} < IDX_LIM);
  assign cnt_ok = idx_ok && (in_data != 8'd0);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    tmo_d   = tmo_q;
    pend_d  = pend_q;
    num_d   = num_q;
    err_d   = err_q;
    cdone_d = 1'b0;
    oidx_d  = oidx_q;
    odata_d = odata_q;
`ifdef SCENE_LOADER_CSUM_EN
    csum_d  = csum_q;
`endif
    err     = 1'b0;

    // frame_sync sees the pending value from before this cycle's update
    if (frame_sync) num_d = pend_q;

    unique case (state_q)
      S_IDLE: begin
        if (acc && in_data == 8'hA5) state_d = S_CMD;
      end
      S_CMD: begin
        if (acc) begin
          if (in_data == 8'h01) state_d = S_IDX;
          else if (in_data == 8'h02) state_d = S_COUNT;
          else err = 1'b1;
        end
      end
      S_IDX: begin
        if (acc) begin
          if (idx_ok) begin
            idx_d   = in_data[OBJ_IDX_WIDTH-1:0];
            bcnt_d  = '0;
            asm_d   = '0;
            state_d = S_DATA;
`ifdef SCENE_LOADER_CSUM_EN
            csum_d  = in_data;
`endif
          end else begin
            err = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (acc) begin
          for (int b = 0; b < OBJ_WIDTH; b++) begin
            if ((b / 8) == int'(bcnt_q)) asm_d[b] = in_data[3'(b % 8)];
          end
          bcnt_d = bcnt_q + BCW'(1);
`ifdef SCENE_LOADER_CSUM_EN
          csum_d = csum_q ^ in_data;
          if (bcnt_q == BCW'(OBJ_BYTES - 1)) state_d = S_CSUM;
`else
          if (bcnt_q == BCW'(OBJ_BYTES - 1)) state_d = S_COMMIT;
`endif
        end
      end
`ifdef SCENE_LOADER_CSUM_EN
      S_CSUM: begin
        if (acc) begin
          if (in_data == csum_q) state_d = S_COMMIT;
          else err = 1'b1;
        end
      end
`endif
      S_COUNT: begin
        if (acc) begin
          state_d = S_IDLE;
          if (cnt_ok) begin
            pend_d  = in_data[OBJ_IDX_WIDTH-1:0];
            cdone_d = 1'b1;
          end else begin
            err = 1'b1;
          end
        end
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (state_q == S_IDLE || state_q == S_COMMIT) begin
      tmo_d = '0;
    end else if (acc) begin
      tmo_d = '0;
    end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      tmo_d = '0;
      err   = 1'b1;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end

    if (err) begin
      state_d = S_IDLE;
      if (err_q != 8'hFF) err_d = err_q + 8'd1;
    end

    // output registers change only when a write is issued
    if (state_d == S_COMMIT && state_q != S_COMMIT) begin
      oidx_d  = idx_q;
      odata_d = asm_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
      tmo_q   <= '0;
      pend_q  <= OBJ_IDX_WIDTH'(INIT_NUM_OBJS);
      num_q   <= OBJ_IDX_WIDTH'(INIT_NUM_OBJS);
      err_q   <= '0;
      cdone_q <= 1'b0;
      oidx_q  <= '0;
      odata_q <= '0;
`ifdef SCENE_LOADER_CSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      tmo_q   <= tmo_d;
      pend_q  <= pend_d;
      num_q   <= num_d;
      err_q   <= err_d;
      cdone_q <= cdone_d;
      oidx_q  <= oidx_d;
      odata_q <= odata_d;
`ifdef SCENE_LOADER_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_scene_loader.sv
// Self-checking bench for scene_loader with a write scoreboard.
// Small geometry: 20-bit objects, 4-bit index, 16-cycle timeout.
module tb_scene_loader;

  localparam int OW = 20;
  localparam int IW = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          frame_sync = 1'b0;
  logic          flash_obj_wen;
  logic [IW-1:0] flash_obj_idx;
  logic [OW-1:0] flash_obj_data;
  logic [IW-1:0] num_objs;
  logic          busy;
  logic          pkt_done;
  logic [7:0]    err_cnt;

  int vec = 0;
  int errs = 0;
  int exp_err = 0;

  logic [IW-1:0] q_idx[$];
  logic [OW-1:0] q_data[$];

  scene_loader #(
    .OBJ_WIDTH(OW),
    .OBJ_IDX_WIDTH(IW),
    .INIT_NUM_OBJS(1),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .frame_sync(frame_sync),
    .flash_obj_wen(flash_obj_wen),
    .flash_obj_idx(flash_obj_idx),
    .flash_obj_data(flash_obj_data),
    .num_objs(num_objs),
    .busy(busy),
    .pkt_done(pkt_done),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // scoreboard: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (!rst && flash_obj_wen === 1'b1) begin
      logic [IW-1:0] ei;
      logic [OW-1:0] ed;
      vec++;
      if (q_idx.size() == 0) begin
        errs++;
        $display("FAIL unexpected_write: idx=%0h data=%0h, none expected",
                 flash_obj_idx, flash_obj_data);
      end else begin
        ei = q_idx.pop_front();
        ed = q_data.pop_front();
        if (flash_obj_idx !== ei || flash_obj_data !== ed ||
            pkt_done !== 1'b1 || in_ready !== 1'b0) begin
          errs++;
          $display("FAIL write: idx=%0h data=%0h done=%b rdy=%b, want idx=%0h data=%0h done=1 rdy=0",
                   flash_obj_idx, flash_obj_data, pkt_done, in_ready, ei, ed);
        end
      end
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic rdy;
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) return;
    end
    vec++;
    errs++;
    $display("FAIL send_stall: in_ready=0 for 8 cycles, want 1");
  endtask

  task automatic pulse_fs();
    frame_sync = 1'b1;
    @(posedge clk);
    #1;
    frame_sync = 1'b0;
  endtask

  task automatic send_write(input logic [7:0] idx, input logic [7:0] d0,
                            input logic [7:0] d1, input logic [7:0] d2);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(idx);
    send_byte(d0);
    send_byte(d1);
    send_byte(d2);
`ifdef SCENE_LOADER_CSUM_EN
    send_byte(idx ^ d0 ^ d1 ^ d2);
`endif
  endtask

  task automatic push_exp(input logic [IW-1:0] i, input logic [OW-1:0] d);
    q_idx.push_back(i);
    q_data.push_back(d);
  endtask

  task automatic check_drained(input string name);
    vec++;
    if (q_idx.size() != 0) begin
      errs++;
      $display("FAIL %s: %0d writes missing, want 0", name, q_idx.size());
      q_idx.delete();
      q_data.delete();
    end
  endtask

  task automatic check_err(input string name);
    vec++;
    if (err_cnt !== 8'(exp_err)) begin
      errs++;
      $display("FAIL %s: err_cnt=%0d, want %0d", name, err_cnt, exp_err);
    end
  endtask

  task automatic check_num(input string name, input logic [IW-1:0] want);
    vec++;
    if (num_objs !== want) begin
      errs++;
      $display("FAIL %s: num_objs=%0d, want %0d", name, num_objs, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(10);
    @(negedge clk);
    vec++;
    if (num_objs !== 4'd1 || err_cnt !== 8'd0 || busy !== 1'b0 ||
        in_ready !== 1'b1 || pkt_done !== 1'b0 ||
        flash_obj_idx !== 4'd0 || flash_obj_data !== 20'd0) begin
      errs++;
      $display("FAIL reset: num=%0d err=%0d busy=%b rdy=%b done=%b idx=%0h data=%0h, want 1 0 0 1 0 0 0",
               num_objs, err_cnt, busy, in_ready, pkt_done, flash_obj_idx, flash_obj_data);
    end
  endtask

  task automatic test_write();
    push_exp(4'd3, 20'hBCDEF);
    send_write(8'h03, 8'hEF, 8'hCD, 8'hAB);
    in_valid = 1'b0;
    @(negedge clk);
    vec++;
    if (flash_obj_wen !== 1'b1) begin
      errs++;
      $display("FAIL write_latency: wen=%b one cycle after last byte, want 1", flash_obj_wen);
    end
    idle(4);
    check_drained("write_done");
    @(negedge clk);
    vec++;
    if (flash_obj_idx !== 4'd3 || flash_obj_data !== 20'hBCDEF || busy !== 1'b0) begin
      errs++;
      $display("FAIL write_hold: idx=%0h data=%0h busy=%b, want 3 bcdef 0",
               flash_obj_idx, flash_obj_data, busy);
    end
  endtask

  task automatic test_count();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h05);
    in_valid = 1'b0;
    @(negedge clk);
    vec++;
    if (pkt_done !== 1'b1) begin
      errs++;
      $display("FAIL count_done: pkt_done=%b, want 1", pkt_done);
    end
    idle(3);
    check_num("count_before_fs", 4'd1);
    pulse_fs();
    check_num("count_after_fs", 4'd5);
    send_byte(8'hA5);
    send_byte(8'h02);
    frame_sync = 1'b1;
    send_byte(8'h07);
    frame_sync = 1'b0;
    in_valid = 1'b0;
    check_num("count_same_cycle", 4'd5);
    idle(2);
    pulse_fs();
    check_num("count_next_fs", 4'd7);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h09);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h0F);
    idle(2);
    pulse_fs();
    check_num("count_last_wins", 4'd15);
  endtask

  task automatic test_errors();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h12);
    idle(2);
    check_err("idle_garbage");
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
    send_byte(8'hA5); send_byte(8'h7F);
    exp_err += 3;
    idle(2);
    check_err("bad_count_cmd");
    pulse_fs();
    check_num("count_unchanged", 4'd15);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
    exp_err += 1;
    idle(2);
    check_err("bad_idx");
    vec++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL err_idle: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_payload_a5();
    push_exp(4'd5, 20'hFA5A5);
    send_write(8'h05, 8'hA5, 8'hA5, 8'hFF);
    idle(3);
    check_drained("payload_a5");
    check_err("payload_a5_err");
  endtask

  task automatic test_timeout();
    send_byte(8'hA5); send_byte(8'h01);
    send_byte(8'h02); send_byte(8'h11);
    in_valid = 1'b0;
    @(negedge clk);
    vec++;
    if (busy !== 1'b1) begin
      errs++;
      $display("FAIL busy_mid: busy=%b, want 1", busy);
    end
    idle(TO + 4);
    exp_err += 1;
    check_err("timeout_err");
    vec++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL timeout_idle: busy=%b, want 0", busy);
    end
    push_exp(4'd15, 20'h30201);
    send_write(8'h0F, 8'h01, 8'h02, 8'h03);
    idle(3);
    check_drained("after_timeout");
  endtask

  task automatic test_back_to_back();
    push_exp(4'd1, 20'h44332);
    push_exp(4'd2, 20'h77665);
    send_write(8'h01, 8'h32, 8'h43, 8'h54);
    send_write(8'h02, 8'h65, 8'h76, 8'h87);
    idle(4);
    check_drained("back_to_back");
    check_err("b2b_err");
  endtask

`ifdef SCENE_LOADER_CSUM_EN
  task automatic test_csum();
    push_exp(4'd1, 20'h02010);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
    send_byte(8'h01);
    idle(3);
    check_drained("csum_good");
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
    send_byte(8'h00);
    exp_err += 1;
    idle(3);
    check_err("csum_bad");
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_count();
    test_errors();
    test_payload_a5();
    test_timeout();
    test_back_to_back();
`ifdef SCENE_LOADER_CSUM_EN
    test_csum();
`endif
    idle(3);
    check_drained("final");
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/scene_loader.md
Name: scene_loader

Overview:
- Byte-stream command decoder that reprograms the scene object memory at runtime, e.g. from UART.
- Parses sync/command packets, assembles object words LSB-first and issues single-cycle flash writes (`flash_obj_wen`/`flash_obj_idx`/`flash_obj_data`) to the scene buffer.
- Holds the active object count; a new count is applied only on a frame boundary so the renderer never sees a count change mid-pass.

Parameters:
- OBJ_WIDTH, 384, bits per object word. OBJ_BYTES = ceil(OBJ_WIDTH/8).
- OBJ_IDX_WIDTH, 8, object index width. Legal range 1..8, so the index fits one byte.
- INIT_NUM_OBJS, 1, value of `num_objs` after reset. Must be ≥1.
- TIMEOUT_CYCLES, 1000000, idle cycles allowed mid-packet before abort.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_data  in  8  stream byte
- in_valid  in  1  byte valid
- in_ready  out  1  loader accepts byte; a transfer occurs when valid&ready
- frame_sync  in  1  one-cycle pulse at the start of a render pass
- flash_obj_wen  out  1  write strobe to the scene buffer
- flash_obj_idx  out  OBJ_IDX_WIDTH  write address
- flash_obj_data  out  OBJ_WIDTH  write data
- num_objs  out  OBJ_IDX_WIDTH  active object count for the scene buffer
- busy  out  1  state != IDLE
- pkt_done  out  1  one-cycle pulse when a packet completes successfully
- err_cnt  out  8  saturating count of errors

Behaviour:
- Reset values: `in_ready`=1, `flash_obj_wen`=0, `flash_obj_idx`=0, `flash_obj_data`=0, `num_objs`=INIT_NUM_OBJS, pending count=INIT_NUM_OBJS, `busy`=0, `pkt_done`=0, `err_cnt`=0, state=IDLE, timeout counter=0.
- Reset mid-packet discards all partial state.
- Packet formats:
  - Write: 0xA5, 0x01, idx, OBJ_BYTES data bytes, [csum].
  - Count: 0xA5, 0x02, count.
- States:
  - IDLE: byte 0xA5 -> CMD. Any other byte is dropped silently, with no error.
  - CMD: 0x01 -> IDX; 0x02 -> COUNT; anything else -> error, IDLE.
  - IDX: if byte ≥ 2**OBJ_IDX_WIDTH -> error, IDLE. Otherwise latch idx, clear byte counter -> DATA.
  - DATA: byte k (0-based) goes to bits [8k+7:8k] of the assembly register. Bits at or above OBJ_WIDTH are discarded. After byte OBJ_BYTES-1 -> COMMIT, or -> CSUM when the optional feature is enabled.
  - COMMIT: lasts exactly 1 cycle.
    - `in_ready`=0.
    - `flash_obj_wen`=1, with `flash_obj_idx`/`flash_obj_data` valid the same cycle.
    - `pkt_done`=1.
    - -> IDLE.
  - COUNT: byte 0, or byte > 2**OBJ_IDX_WIDTH-1 -> error. Otherwise the pending count is written and `pkt_done` pulses the next cycle. -> IDLE in both cases.
- Write latency: `flash_obj_wen` asserts the cycle after the last data byte (or csum byte) is accepted.
- `flash_obj_idx`/`flash_obj_data` hold their last written value when `flash_obj_wen`=0.
- `in_ready` is 1 in every state except COMMIT.
- Count commit:
  - On `frame_sync`, `num_objs` <= pending count.
  - If the pending count and `frame_sync` update in the same cycle, `frame_sync` applies the old pending value. The new value is applied at the next `frame_sync`.
  - Multiple count packets between frames: the last one wins.
- Timeout: in any state other than IDLE/COMMIT, the counter increments each cycle with no accepted byte and resets on acceptance. On reaching TIMEOUT_CYCLES-1 -> error, IDLE.
- Error: `err_cnt` <= min(err_cnt+1, 255); no flash write and no `pkt_done` occur.
- A 0xA5 byte inside IDX/DATA/COUNT is treated as payload, not as resync.

Optional Feature:
- Macro: SCENE_LOADER_CSUM_EN.
- Enabled:
  - Write packets carry a trailing csum byte equal to the XOR of the idx byte and all data bytes. The CSUM state compares it.
  - Match -> COMMIT. Mismatch -> error, no write, IDLE.
  - Count packets are unchanged.
- Disabled:
  - No CSUM state; DATA goes directly to COMMIT.
  - A trailing byte would be parsed as an IDLE byte.

Test Plan (bench uses OBJ_WIDTH=20, OBJ_BYTES=3, OBJ_IDX_WIDTH=4, csum disabled unless noted):
- Reset, then idle 10 cycles -> `num_objs`=INIT_NUM_OBJS, `err_cnt`=0, `busy`=0, `in_ready`=1, no `flash_obj_wen`.
- Send A5 01 03 EF CD AB with `in_valid` held high -> one `flash_obj_wen` pulse the cycle after AB, `flash_obj_idx`=3, `flash_obj_data`=0xBCDEF (upper nibble of AB dropped), `in_ready`=0 that cycle, `pkt_done`=1.
- Send A5 02 05, `frame_sync` 3 cycles later -> `num_objs` stays at its old value until `frame_sync`, then =5.
- Send A5 02 00, then A5 02 10 (16 > 15), then A5 7F -> `err_cnt`=3, pending count unchanged, `num_objs` unchanged after `frame_sync`.
- Send A5 01 02 11, then `in_valid`=0 for TIMEOUT_CYCLES (bench overrides to 16) -> `err_cnt`+1, `busy`=0, no write; a following valid write packet commits normally.
- SCENE_LOADER_CSUM_EN:
  - A5 01 01 10 20 30 csum=0x01^0x10^0x20^0x30=0x01 -> write, idx 1, data 0x02010.
  - The same packet with csum 0x00 -> no write, `err_cnt`+1.
